// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared encodings for the sequential FP add/subtract unit
package fpu_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ALIGN = 3'd1;
   localparam logic [2:0] ST_ADD   = 3'd2;
   localparam logic [2:0] ST_NORM  = 3'd3;
   localparam logic [2:0] ST_ROUND = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_SUB,
      CLS_NORM,
      CLS_INF,
      CLS_QNAN,
      CLS_SNAN
   } fp_class_e;

   // flags = {invalid, overflow, underflow, inexact}
   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_INX = 0;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Positive quiet NaN with only the fraction MSB set; callers truncate to their word width.
   function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) begin
         r[i] = (i >= man_w - 1) && (i < man_w + exp_w);
      end
      return r;
   endfunction

endpackage

// File: rtl/fpu_lzc.sv
// rtl/fpu_lzc.sv - leading-zero counter with a left shifter for normalisation
module fpu_lzc #(
   parameter int WIDTH = 27,
   localparam int CW = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] data,
   input  logic [CW-1:0]    amount,
   output logic [CW-1:0]    count,
   output logic             zero,
   output logic [WIDTH-1:0] shifted
);

   always_comb begin
      count = CW'(WIDTH);
      // Ascending scan: the last hit is the most significant set bit.
      for (int i = 0; i < WIDTH; i++) begin
         if (data[i]) count = CW'(WIDTH - 1 - i);
      end
      zero    = ~|data;
      shifted = data << amount;
   end

endmodule

// File: rtl/fpu_addsub_seq.sv
// rtl/fpu_addsub_seq.sv - multi-cycle IEEE-754 add/subtract, round-to-nearest-even
module fpu_addsub_seq
   import fpu_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic [3:0]   flags
);

   localparam int DW     = MAN_W + 5;
   localparam int EW     = EXP_W + 1;
   localparam int MAX_SH = MAN_W + 3;
   localparam int SH_W   = $clog2(DW + 1);
   localparam int LZ_CW  = $clog2(DW);
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [W-1:0] NAN_WORD = W'(canon_nan(EXP_W, MAN_W));

   logic [2:0]    state;
   logic [W-1:0]  a_q, b_q;
   logic [DW-1:0] sig_l_q, sig_s_q, sum_q;
   logic [EW-1:0] exp_q;
   logic          sign_q, sub_q, zsign_q, zero_q;
   logic          sp_nan_q, sp_inv_q, sp_inf_q;

   function automatic fp_class_e classify(input logic [W-2:0] x);
      if (x[W-2:MAN_W] == EXP_ONES) begin
         if (x[MAN_W-1:0] == '0) return CLS_INF;
         return x[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
      end
      if (x[W-2:MAN_W] == '0) return (x[MAN_W-1:0] == '0) ? CLS_ZERO : CLS_SUB;
      return CLS_NORM;
   endfunction

   // Unpack, order by magnitude and align the smaller operand.
   fp_class_e        ca, cb;
   logic             swap, a_nan, b_nan, a_inf, b_inf, inf_clash;
   logic [W-1:0]     xl, xs;
   logic [EXP_W-1:0] el, es, diff;
   logic [DW-1:0]    sl, ss, ss_al, lost_mask;
   logic [SH_W-1:0]  sh;

   always_comb begin
      ca        = classify(a_q[W-2:0]);
      cb        = classify(b_q[W-2:0]);
      a_nan     = (ca == CLS_QNAN) || (ca == CLS_SNAN);
      b_nan     = (cb == CLS_QNAN) || (cb == CLS_SNAN);
      a_inf     = (ca == CLS_INF);
      b_inf     = (cb == CLS_INF);
      inf_clash = a_inf && b_inf && (a_q[W-1] != b_q[W-1]);
      swap      = b_q[W-2:0] > a_q[W-2:0];
      xl        = swap ? b_q : a_q;
      xs        = swap ? a_q : b_q;
      el        = (xl[W-2:MAN_W] == '0) ? EXP_W'(1) : xl[W-2:MAN_W];
      es        = (xs[W-2:MAN_W] == '0) ? EXP_W'(1) : xs[W-2:MAN_W];
      sl        = {1'b0, |xl[W-2:MAN_W], xl[MAN_W-1:0], 3'b000};
      ss        = {1'b0, |xs[W-2:MAN_W], xs[MAN_W-1:0], 3'b000};
      diff      = el - es;
      sh        = (32'(diff) > MAX_SH) ? SH_W'(MAX_SH) : SH_W'(diff);
      lost_mask = ~({DW{1'b1}} << sh);
      ss_al     = (ss >> sh) | {{(DW-1){1'b0}}, |(ss & lost_mask)};
   end

   // Normalisation shift is capped so the exponent never drops below 1.
   logic [EW-1:0]    em1;
   logic [LZ_CW-1:0] lz_lim, lz_count, lz_amt;
   logic             lz_zero;
   logic [DW-2:0]    lz_shifted;

   always_comb begin
      em1    = exp_q - EW'(1);
      lz_lim = (32'(em1) > (DW - 1)) ? LZ_CW'(DW - 1) : LZ_CW'(em1);
      lz_amt = (lz_count < lz_lim) ? lz_count : lz_lim;
   end

   fpu_lzc #(.WIDTH(DW - 1)) u_lzc (
      .data    (sum_q[DW-2:0]),
      .amount  (lz_amt),
      .count   (lz_count),
      .zero    (lz_zero),
      .shifted (lz_shifted)
   );

   logic [MAN_W:0]   m;
   logic [MAN_W+1:0] mr;
   logic             inx, rup, ovf, unf;
   logic [EW-1:0]    fe;
   logic [MAN_W-1:0] fr;
   logic [W-1:0]     res_c;
   logic [3:0]       flg_c;

   always_comb begin
      m   = sum_q[DW-2:3];
      inx = |sum_q[2:0];
      rup = sum_q[2] & (sum_q[1] | sum_q[0] | m[0]);
      mr  = {1'b0, m} + (MAN_W+2)'(rup);
      if (mr[MAN_W+1]) begin
         fe = exp_q + EW'(1);
         fr = mr[MAN_W:1];
      end else begin
         // A subnormal that rounded into the hidden bit keeps exp 1: minimum normal.
         fe = mr[MAN_W] ? exp_q : '0;
         fr = mr[MAN_W-1:0];
      end
      ovf   = fe >= {1'b0, EXP_ONES};
      unf   = (fe == '0) && inx;
      flg_c = '0;
      if (sp_nan_q) begin
         res_c          = NAN_WORD;
         flg_c[FLG_INV] = sp_inv_q;
      end else if (sp_inf_q) begin
         res_c = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      end else if (ovf) begin
         res_c          = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
         flg_c[FLG_OVF] = 1'b1;
         flg_c[FLG_INX] = 1'b1;
      end else begin
         res_c          = {zero_q ? zsign_q : sign_q, fe[EXP_W-1:0], fr};
         flg_c[FLG_UNF] = unf;
         flg_c[FLG_INX] = inx;
      end
   end

   assign in_ready = rst && (state == ST_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sig_l_q   <= '0;
         sig_s_q   <= '0;
         sum_q     <= '0;
         exp_q     <= '0;
         sign_q    <= 1'b0;
         sub_q     <= 1'b0;
         zsign_q   <= 1'b0;
         zero_q    <= 1'b0;
         sp_nan_q  <= 1'b0;
         sp_inv_q  <= 1'b0;
         sp_inf_q  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= (op == OP_SUB) ? {~b[W-1], b[W-2:0]} : b;
                  state <= ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               sig_l_q  <= sl;
               sig_s_q  <= ss_al;
               exp_q    <= {1'b0, el};
               sign_q   <= xl[W-1];
               sub_q    <= xl[W-1] ^ xs[W-1];
               zsign_q  <= a_q[W-1] & b_q[W-1];
               sp_nan_q <= a_nan || b_nan || inf_clash;
               sp_inv_q <= (ca == CLS_SNAN) || (cb == CLS_SNAN) || inf_clash;
               sp_inf_q <= a_inf || b_inf;
               state    <= ST_ADD;
            end
            ST_ADD: begin
               sum_q <= sub_q ? (sig_l_q - sig_s_q) : (sig_l_q + sig_s_q);
               state <= ST_NORM;
            end
            ST_NORM: begin
               if (sum_q[DW-1]) begin
                  sum_q  <= {1'b0, sum_q[DW-1:2], sum_q[1] | sum_q[0]};
                  exp_q  <= exp_q + EW'(1);
                  zero_q <= 1'b0;
               end else begin
                  sum_q  <= {1'b0, lz_shifted};
                  exp_q  <= exp_q - EW'(lz_amt);
                  zero_q <= lz_zero;
               end
               state <= ST_ROUND;
            end
            ST_ROUND: begin
               result <= res_c;
               flags  <= flg_c;
               state  <= ST_DONE;
            end
            ST_DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// tb/tb_fpu_addsub_seq.sv - vector table plus scoreboard bench for fpu_addsub_seq
module tb_fpu_addsub_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, op, out_valid, out_ready;
   logic [31:0] a, b, result;
   logic [3:0]  flags;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [31:0] res;
      logic [3:0]  flg;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic [3:0]  flg;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   fpu_addsub_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: unexpected result %h flags %b", result, flags);
         end else begin
            mon_e = sb_q.pop_front();
            if (result !== mon_e.res || flags !== mon_e.flg) begin
               errors++;
               $display("FAIL %s: result %h flags %b, expected %h flags %b",
                        mon_e.name, result, flags, mon_e.res, mon_e.flg);
            end
         end
      end
   end

   task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tb,
                         input logic top, input logic [31:0] er, input logic [3:0] ef,
                         input int hold);
      exp_t e;
      int   lat;
      bit   got;
      @(posedge clk); #1;
      a = ta; b = tb; op = top; in_valid = 1'b1; out_ready = (hold == 0);
      got = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s_accept: in_ready stayed 0, expected 1", nm);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      e.name = nm; e.res = er; e.flg = ef;
      sb_q.push_back(e);
      #1;
      in_valid = 1'b0; a = $urandom; b = $urandom; op = ~top;
      lat = 0; got = 1'b0;
      while (lat < 20 && !got) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         got = out_valid;
      end
      checks++;
      if (!got || lat != 5) begin
         errors++;
         $display("FAIL %s_latency: %0d cycles (out_valid %0b), expected 5", nm, lat, got);
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (!(out_valid === 1'b1 && in_ready === 1'b0 && result === er && flags === ef)) begin
            errors++;
            $display("FAIL %s_stall%0d: out_valid %0b in_ready %0b result %h flags %b, expected 1 0 %h %b",
                     nm, h, out_valid, in_ready, result, flags, er, ef);
         end
      end
      if (hold > 0) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1;
   endtask

   vec_t vt[14];

   initial begin
      bit seen_valid;
      vt[0]  = '{"sub_to_pos_zero", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
      vt[1]  = '{"neg_zero_sum",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
      vt[2]  = '{"inf_minus_inf",   32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000};
      vt[3]  = '{"snan_in",         32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
      vt[4]  = '{"qnan_in",         32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
      vt[5]  = '{"overflow",        32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
      vt[6]  = '{"sub_plus_sub",    32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000};
      vt[7]  = '{"minnorm_minus",   32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 4'b0000};
      vt[8]  = '{"tie_even_down",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
      vt[9]  = '{"tie_odd_up",      32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
      vt[10] = '{"three_minus_one", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000};
      vt[11] = '{"inf_plus_fin",    32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0000};
      vt[12] = '{"neg1_plus_1",     32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4'b0000};
      vt[13] = '{"one_minus_neg1",  32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 4'b0000};

      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 32'h0 || flags !== 4'h0) begin
         errors++;
         $display("FAIL reset_state: out_valid %0b in_ready %0b result %h flags %b, expected 0 0 0 0",
                  out_valid, in_ready, result, flags);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: in_ready %0b, expected 1", in_ready);
      end

      run_op("add_backpressure", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 3);

      for (int i = 0; i < 14; i++) begin
         run_op(vt[i].name, vt[i].a, vt[i].b, vt[i].op, vt[i].res, vt[i].flg, 0);
      end

      // Reset while the operation sits in NORM: accept edge, then ALIGN->ADD, ADD->NORM.
      @(posedge clk); #1;
      a = 32'h3F800000; b = 32'h40000000; op = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_accept: in_ready %0b, expected 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 32'h0 || flags !== 4'h0) begin
         errors++;
         $display("FAIL midreset_state: out_valid %0b in_ready %0b result %h flags %b, expected 0 0 0 0",
                  out_valid, in_ready, result, flags);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      seen_valid = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid || !in_ready) seen_valid = 1'b1;
      end
      checks++;
      if (seen_valid) begin
         errors++;
         $display("FAIL midreset_idle: partial result or busy after reset, expected idle");
      end
      run_op("after_reset", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000, 0);

      repeat (2) @(posedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
